// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM inference datapath.
package svm_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SCALE} dot_state_t;

    localparam int IMG_DIM     = 28;
    localparam int IMG_SIZE    = IMG_DIM * IMG_DIM;
    localparam int DESKEW_BASE = 784;
    localparam int FRAC        = 14;

endpackage

// File: rtl/svm_mac.sv
// Signed multiply-accumulate.
// Operand a is an unsigned pixel and operand b is a signed SV element.
// The accumulator keeps full precision.
module svm_mac #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        en,
    input  logic        [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] acc
);
    import svm_pkg::*;

    logic signed [WIDTH:0]   a_ext;
    logic signed [2*WIDTH:0] product;

    // Treat the pixel as non-negative and form the exact 2*WIDTH+1-bit signed product
    always_comb begin
        a_ext   = {1'b0, a};
        product = (2*WIDTH+1)'(a_ext) * (2*WIDTH+1)'(b);
    end

    // Accumulator: clear has priority over accumulate; the product is sign-extended
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_WIDTH'(product);
        end
    end

endmodule

// File: rtl/svm_dot_engine.sv
// Streams the deskewed image against one support vector.
// Produces the saturated fixed-point dot product for the SVM decision logic.
module svm_dot_engine #(
    parameter int WIDTH     = 16,
    parameter int FRAC      = svm_pkg::FRAC,
    parameter int IMG_BASE  = svm_pkg::DESKEW_BASE,
    parameter int IMG_SIZE  = svm_pkg::IMG_SIZE,
    parameter int SV_AW     = 16,
    parameter int ACC_WIDTH = 48,
    parameter int RES_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        ready,
    input  logic        [SV_AW-1:0]     sv_base,
    output logic        [10:0]          img_address,
    output logic                        img_en,
    input  logic        [WIDTH-1:0]     img_data,
    output logic        [SV_AW-1:0]     sv_address,
    output logic                        sv_en,
    input  logic        [WIDTH-1:0]     sv_data,
    output logic signed [RES_WIDTH-1:0] result,
    output logic                        result_valid
);
    import svm_pkg::*;

    localparam int IDX_W = $clog2(IMG_SIZE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);

    dot_state_t                  state, state_next;
    logic        [IDX_W-1:0]     idx;
    logic        [SV_AW-1:0]     sv_base_q;
    logic                        rd_d;
    logic                        go;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] scaled;
    logic signed [RES_WIDTH-1:0] saturated;

    svm_mac #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (go),
        .en    (rd_d),
        .a     (img_data),
        .b     (sv_data),
        .acc   (acc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus memory/handshake outputs decoded from the current state
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        go          = 1'b0;
        img_en      = 1'b0;
        sv_en       = 1'b0;
        img_address = '0;
        sv_address  = '0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    go         = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                img_en      = 1'b1;
                sv_en       = 1'b1;
                img_address = 11'(IMG_BASE) + 11'(idx);
                sv_address  = sv_base_q + SV_AW'(idx);
                if (idx == LAST_IDX) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = SCALE;
            end
            SCALE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Drop the fraction bits (floor) and clamp to the signed result range
    always_comb begin
        scaled    = acc >>> FRAC;
        saturated = scaled[RES_WIDTH-1:0];
        if (scaled[ACC_WIDTH-1:RES_WIDTH-1] != '0 &&
            scaled[ACC_WIDTH-1:RES_WIDTH-1] != '1) begin
            saturated = scaled[ACC_WIDTH-1] ? {1'b1, {(RES_WIDTH-1){1'b0}}}
                                            : {1'b0, {(RES_WIDTH-1){1'b1}}};
        end
    end

    // Element counter, read-return flag, latched SV base and the registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            rd_d         <= 1'b0;
            sv_base_q    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            rd_d         <= (state == FETCH);
            result_valid <= 1'b0;
            if (go) begin
                sv_base_q <= sv_base;
                idx       <= '0;
            end else if (state == FETCH) begin
                idx <= idx + 1'b1;
            end
            if (state == SCALE) begin
                result       <= saturated;
                result_valid <= 1'b1;
            end
        end
    end

endmodule
